// File: rtl/itf_off_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : itf_off_port_pkg
// Purpose  : Shared state encoding and command-word field positions for the
//            off-chip handshake port.
// Revision : 1.0  initial release
// ============================================================================
package itf_off_port_pkg;

  // Command word layout: {zeros, Num, Addr, Dir}, Dir in bit 0.
  localparam int CMD_DIR_BIT  = 0;
  localparam int CMD_ADDR_LSB = 1;

  // Num field sits directly above the address field.
  function automatic int cmdNumLsb(input int dramAddrWidth);
    return CMD_ADDR_LSB + dramAddrWidth;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISARX  = 3'd1,
    ST_CMD    = 3'd2,
    ST_DATIN  = 3'd3,
    ST_DATOUT = 3'd4,
    ST_MONOUT = 3'd5
  } itf_state_t;

endpackage
`default_nettype wire

// File: rtl/itf_beat_pack.sv
`default_nettype none
// ============================================================================
// Module   : itf_beat_pack
// Purpose  : 128-bit pad beat <-> 256-bit word conversion. Unpack side keeps
//            the low half and a 1-deep output register; pack side holds one
//            popped word and serves it low half first.
// Revision : 1.0  initial release
// ============================================================================
module itf_beat_pack #(
  parameter int PORT_WIDTH = 128,
  parameter int INT_WIDTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inEn,
  input  logic                  outEn,
  input  logic                  hiHalf,
  input  logic [PORT_WIDTH-1:0] beatIn,
  input  logic                  beatInVld,
  output logic                  inRdy,
  output logic [INT_WIDTH-1:0]  wrDat,
  output logic                  wrVld,
  input  logic                  wrRdy,
  input  logic [INT_WIDTH-1:0]  rdDat,
  input  logic                  rdVld,
  output logic                  rdRdy,
  output logic [PORT_WIDTH-1:0] beatOut,
  output logic                  beatOutVld,
  input  logic                  beatOutRdy
);

  logic [PORT_WIDTH-1:0] lowHalf;
  logic [INT_WIDTH-1:0]  wordR;
  logic                  haveR;
  logic                  inAcc;

  // Low half always fits; high half needs the output register free or draining.
  assign inRdy = inEn & (~hiHalf | wrRdy | ~wrVld);
  assign inAcc = inRdy & beatInVld;

  // Unpack: capture low half, then merge with the high half into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lowHalf <= '0;
      wrDat   <= '0;
      wrVld   <= 1'b0;
    end else begin
      if (inAcc && !hiHalf) lowHalf <= beatIn;
      if (inAcc && hiHalf) begin
        wrDat <= {beatIn, lowHalf};
        wrVld <= 1'b1;
      end else if (wrRdy) begin
        wrVld <= 1'b0;
      end
    end
  end

  assign rdRdy      = outEn & ~haveR;
  assign beatOutVld = outEn & haveR;
  assign beatOut    = hiHalf ? wordR[INT_WIDTH-1:PORT_WIDTH] : wordR[PORT_WIDTH-1:0];

  // Pack: hold one word until its high half has been accepted by the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordR <= '0;
      haveR <= 1'b0;
    end else if (rdRdy && rdVld) begin
      wordR <= rdDat;
      haveR <= 1'b1;
    end else if (beatOutVld && beatOutRdy && hiHalf) begin
      haveR <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/itf_off_port.sv
`default_nettype none
// ============================================================================
// Module   : itf_off_port
// Purpose  : Chip-side end of the 128-bit off-chip handshake bus. Forwards
//            ISA beats to the decoder, issues DRAM commands for GLB requests
//            and moves write/read data between host beats and GLB words.
//            Define ITF_MON_EN to include the monitor dump (MONOUT) path.
// Revision : 1.0  initial release
// ============================================================================
module itf_off_port
  import itf_off_port_pkg::*;
#(
  parameter int PORT_WIDTH      = 128,
  parameter int INT_WIDTH       = 256,
  parameter int ADDR_WIDTH      = 16,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int MON_BEATS       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORT_WIDTH-1:0]           I_Dat,
  output logic [PORT_WIDTH-1:0]           O_Dat,
  output logic                            O_DatOE,
  input  logic                            I_ISAVld,
  input  logic                            I_DatVld,
  input  logic                            I_DatLast,
  output logic                            O_DatRdy,
  output logic                            O_DatVld,
  output logic                            O_DatLast,
  input  logic                            I_DatRdy,
  output logic                            O_CmdVld,
  output logic                            O_ISAVld,
  output logic                            O_ISALast,
  input  logic                            I_ISARdy,
  output logic [PORT_WIDTH-1:0]           O_ISADat,
  input  logic                            I_CmdReqVld,
  output logic                            O_CmdReqRdy,
  input  logic                            I_CmdDir,
  input  logic [DRAM_ADDR_WIDTH-1:0]      I_CmdAddr,
  input  logic [ADDR_WIDTH-1:0]           I_CmdNum,
  output logic [INT_WIDTH-1:0]            O_WrDat,
  output logic                            O_WrVld,
  input  logic                            I_WrRdy,
  input  logic [INT_WIDTH-1:0]            I_RdDat,
  input  logic                            I_RdVld,
  output logic                            O_RdRdy,
  input  logic                            I_MonReq,
  input  logic [MON_BEATS*PORT_WIDTH-1:0] I_MonDat,
  output logic                            O_MonAck,
  output logic                            O_ErrLen
);

  localparam int CMD_NUM_LSB = cmdNumLsb(DRAM_ADDR_WIDTH);
  localparam int CNT_W       = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  itf_state_t                 state, nextState;
  logic [CNT_W-1:0]           cnt;
  logic                       cmdDir;
  logic [DRAM_ADDR_WIDTH-1:0] cmdAddr;
  logic [ADDR_WIDTH-1:0]      cmdNum;
  logic                       errLen;
  logic                       datOE;
  logic [PORT_WIDTH-1:0]      cmdWord;
  logic [PORT_WIDTH-1:0]      outBeat;
  logic [PORT_WIDTH-1:0]      monBeat;
  logic                       inRdy, outVld;
  logic                       cntZero, hiHalf, inEn, outEn;
  logic                       isaStart, cmdTake, monTake;
  logic                       isaAcc, cmdAcc, inAcc, outAcc, monAcc;

  assign cntZero  = (cnt == '0);
  assign hiHalf   = ~cnt[0];      // counter starts odd, so the low half comes first
  assign inEn     = (state == ST_DATIN);
  assign outEn    = (state == ST_DATOUT);
  // A host ISA transfer already on the bus beats a new command.
  assign isaStart = (state == ST_IDLE) & I_ISAVld & I_DatVld;
  assign cmdTake  = (state == ST_IDLE) & ~isaStart & I_CmdReqVld & (I_CmdNum != '0);
  assign isaAcc   = (state == ST_ISARX) & I_DatVld & I_ISARdy;
  assign cmdAcc   = (state == ST_CMD) & I_DatRdy;
  assign inAcc    = inEn & I_DatVld & inRdy;
  assign outAcc   = outEn & outVld & I_DatRdy;
  assign monAcc   = (state == ST_MONOUT) & I_DatRdy;

`ifdef ITF_MON_EN
  logic [MON_BEATS*PORT_WIDTH-1:0] monBuf;
  logic                            monAckR;

  assign monTake  = (state == ST_IDLE) & ~isaStart & ~cmdTake & I_MonReq;
  assign monBeat  = monBuf[PORT_WIDTH-1:0];
  assign O_MonAck = monAckR;

  // Snapshot on entry, then shift one beat out per accept; ack the cycle after the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      monBuf  <= '0;
      monAckR <= 1'b0;
    end else begin
      monAckR <= monAcc & cntZero;
      if (monTake)     monBuf <= I_MonDat;
      else if (monAcc) monBuf <= monBuf >> PORT_WIDTH;
    end
  end
`else
  logic unusedMon;
  assign unusedMon = ^{I_MonReq, I_MonDat};
  assign monTake   = 1'b0;
  assign monBeat   = '0;
  assign O_MonAck  = 1'b0;
`endif

  // Command word assembled from the latched request fields.
  always_comb begin
    cmdWord = '0;
    cmdWord[CMD_DIR_BIT] = cmdDir;
    cmdWord[CMD_ADDR_LSB +: DRAM_ADDR_WIDTH] = cmdAddr;
    cmdWord[CMD_NUM_LSB +: ADDR_WIDTH] = cmdNum;
  end

  itf_beat_pack #(
    .PORT_WIDTH (PORT_WIDTH),
    .INT_WIDTH  (INT_WIDTH)
  ) uPack (
    .clk        (clk),
    .rst        (rst),
    .inEn       (inEn),
    .outEn      (outEn),
    .hiHalf     (hiHalf),
    .beatIn     (I_Dat),
    .beatInVld  (I_DatVld),
    .inRdy      (inRdy),
    .wrDat      (O_WrDat),
    .wrVld      (O_WrVld),
    .wrRdy      (I_WrRdy),
    .rdDat      (I_RdDat),
    .rdVld      (I_RdVld),
    .rdRdy      (O_RdRdy),
    .beatOut    (outBeat),
    .beatOutVld (outVld),
    .beatOutRdy (I_DatRdy)
  );

  // State register; bus enable follows the next state so it drops before host data is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      datOE <= 1'b0;
    end else begin
      state <= nextState;
      datOE <= (nextState == ST_CMD) | (nextState == ST_DATOUT) | (nextState == ST_MONOUT);
    end
  end

  // Request latch, beat counter and sticky length-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cmdDir  <= 1'b0;
      cmdAddr <= '0;
      cmdNum  <= '0;
      errLen  <= 1'b0;
    end else begin
      if (cmdTake) begin
        cmdDir  <= I_CmdDir;
        cmdAddr <= I_CmdAddr;
        cmdNum  <= I_CmdNum;
      end
      if (cmdAcc)                      cnt <= {cmdNum, 1'b0} - CNT_ONE;
      else if (monTake)                cnt <= CNT_W'(MON_BEATS - 1);
      else if (inAcc | outAcc | monAcc) cnt <= cnt - CNT_ONE;
      if (inAcc && (I_DatLast != cntZero)) errLen <= 1'b1;
    end
  end

  // Next-state and bus/stream outputs.
  always_comb begin
    nextState   = state;
    O_Dat       = '0;
    O_DatVld    = 1'b0;
    O_DatLast   = 1'b0;
    O_CmdVld    = 1'b0;
    O_DatRdy    = 1'b0;
    O_ISAVld    = 1'b0;
    O_ISALast   = 1'b0;
    O_ISADat    = '0;
    O_CmdReqRdy = 1'b0;
    case (state)
      ST_IDLE: begin
        O_CmdReqRdy = cmdTake;
        if (isaStart)     nextState = ST_ISARX;
        else if (cmdTake) nextState = ST_CMD;
        else if (monTake) nextState = ST_MONOUT;
      end
      ST_ISARX: begin
        O_DatRdy  = I_ISARdy;
        O_ISAVld  = I_DatVld;
        O_ISALast = I_DatLast;
        O_ISADat  = I_Dat;
        if (isaAcc && I_DatLast) nextState = ST_IDLE;
      end
      ST_CMD: begin
        O_Dat     = cmdWord;
        O_DatVld  = 1'b1;
        O_DatLast = 1'b1;
        O_CmdVld  = 1'b1;
        if (cmdAcc) nextState = cmdDir ? ST_DATOUT : ST_DATIN;
      end
      ST_DATIN: begin
        O_DatRdy = inRdy;
        if (inAcc && cntZero) nextState = ST_IDLE;
      end
      ST_DATOUT: begin
        O_Dat     = outBeat;
        O_DatVld  = outVld;
        O_DatLast = outVld & cntZero;
        if (outAcc && cntZero) nextState = ST_IDLE;
      end
      ST_MONOUT: begin
        O_Dat     = monBeat;
        O_DatVld  = 1'b1;
        O_DatLast = cntZero;
        if (monAcc && cntZero) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  assign O_DatOE  = datOE;
  assign O_ErrLen = errLen;

endmodule
`default_nettype wire

// File: tb/tb_itf_off_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_itf_off_port
// Purpose  : Directed self-checking bench for itf_off_port: ISA pass-through,
//            write and read commands, length error, ISA/command priority,
//            mid-transfer reset and the monitor path (ITF_MON_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_itf_off_port;

  localparam int PW = 128;
  localparam int IW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic [PW-1:0]   I_Dat, O_Dat, O_ISADat;
  logic            O_DatOE, I_ISAVld, I_DatVld, I_DatLast, O_DatRdy;
  logic            O_DatVld, O_DatLast, I_DatRdy, O_CmdVld;
  logic            O_ISAVld, O_ISALast, I_ISARdy;
  logic            I_CmdReqVld, O_CmdReqRdy, I_CmdDir;
  logic [31:0]     I_CmdAddr;
  logic [15:0]     I_CmdNum;
  logic [IW-1:0]   O_WrDat, I_RdDat;
  logic            O_WrVld, I_WrRdy, I_RdVld, O_RdRdy;
  logic            I_MonReq, O_MonAck, O_ErrLen;
  logic [16*PW-1:0] I_MonDat;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  itf_off_port dut (
    .clk(clk), .rst(rst), .I_Dat(I_Dat), .O_Dat(O_Dat), .O_DatOE(O_DatOE),
    .I_ISAVld(I_ISAVld), .I_DatVld(I_DatVld), .I_DatLast(I_DatLast), .O_DatRdy(O_DatRdy),
    .O_DatVld(O_DatVld), .O_DatLast(O_DatLast), .I_DatRdy(I_DatRdy), .O_CmdVld(O_CmdVld),
    .O_ISAVld(O_ISAVld), .O_ISALast(O_ISALast), .I_ISARdy(I_ISARdy), .O_ISADat(O_ISADat),
    .I_CmdReqVld(I_CmdReqVld), .O_CmdReqRdy(O_CmdReqRdy), .I_CmdDir(I_CmdDir),
    .I_CmdAddr(I_CmdAddr), .I_CmdNum(I_CmdNum), .O_WrDat(O_WrDat), .O_WrVld(O_WrVld),
    .I_WrRdy(I_WrRdy), .I_RdDat(I_RdDat), .I_RdVld(I_RdVld), .O_RdRdy(O_RdRdy),
    .I_MonReq(I_MonReq), .I_MonDat(I_MonDat), .O_MonAck(O_MonAck), .O_ErrLen(O_ErrLen)
  );

  function automatic logic [PW-1:0] mkBeat(input logic [31:0] base, input int k);
    return {base, 64'h0123_4567_89AB_CDEF, k[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk(tag, {O_DatOE, O_DatVld, O_DatLast, O_CmdVld, O_ISAVld, O_ISALast, O_WrVld,
              O_RdRdy, O_MonAck, O_ErrLen, O_CmdReqRdy, O_DatRdy}, '0);
    chk({tag, "_dat"}, {O_Dat, O_ISADat}, '0);
    chk({tag, "_wrdat"}, O_WrDat, '0);
  endtask

  // Host sends n ISA beats with I_ISARdy toggling 1/0.
  task automatic isaXfer(input int n, input logic [31:0] base);
    int k; int cyc; bit r; bit acc;
    k = 1; cyc = 0; r = 1'b1;
    I_ISAVld = 1; I_DatVld = 1; I_Dat = mkBeat(base, 1); I_DatLast = (n == 1);
    while (k <= n && cyc < 200) begin
      I_ISARdy = r;
      @(negedge clk);
      acc = I_DatVld && O_DatRdy;
      chk("isa_cmd_blocked", O_CmdReqRdy, 0);
      if (acc) begin
        chk("isa_vld", O_ISAVld, 1);
        chk("isa_dat", O_ISADat, mkBeat(base, k));
        chk("isa_last", O_ISALast, (k == n));
      end
      @(posedge clk); #1;
      if (acc) k++;
      if (k <= n) begin
        I_Dat = mkBeat(base, k); I_DatLast = (k == n);
      end else begin
        I_ISAVld = 0; I_DatVld = 0; I_DatLast = 0; I_Dat = '0;
      end
      r = ~r; cyc++;
    end
    I_ISARdy = 0;
    chk("isa_beats", k - 1, n);
  endtask

  // Request a command and take the command word off the bus.
  task automatic issueCmd(input bit dir, input logic [31:0] addr, input logic [15:0] num);
    int cyc; bit seen;
    I_CmdReqVld = 1; I_CmdDir = dir; I_CmdAddr = addr; I_CmdNum = num;
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk); seen = O_CmdReqRdy;
      @(posedge clk); #1; cyc++;
    end
    chk("cmd_req_rdy", seen, 1);
    I_CmdReqVld = 0; I_DatRdy = 1;
    @(negedge clk);
    chk("cmd_word", O_Dat, {79'd0, num, addr, dir});
    chk("cmd_flags", {O_DatOE, O_CmdVld, O_DatVld, O_DatLast}, 4'b1111);
    @(posedge clk); #1;
    I_DatRdy = 0;
  endtask

  // Host writes nBeats beats (I_DatLast on beat lastPos); GLB side collects words.
  task automatic hostWrite(input int nBeats, input int lastPos, input bit toggleWr, input logic [31:0] seed);
    int sent; int words; int cyc; bit wr; bit acc;
    sent = 0; words = 0; cyc = 0; wr = 1'b1;
    I_ISAVld = 0; I_DatVld = 1; I_Dat = mkBeat(seed, 0); I_DatLast = (lastPos == 1);
    while ((sent < nBeats || words < nBeats / 2) && cyc < 200) begin
      I_WrRdy = wr;
      @(negedge clk);
      acc = I_DatVld && O_DatRdy;
      chk("oe_in", O_DatOE, 0);
      if (O_WrVld && I_WrRdy) begin
        chk("wr_dat", O_WrDat, {mkBeat(seed, 2 * words + 1), mkBeat(seed, 2 * words)});
        words++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      if (sent < nBeats) begin
        I_Dat = mkBeat(seed, sent); I_DatLast = (sent + 1 == lastPos);
      end else begin
        I_DatVld = 0; I_DatLast = 0;
      end
      if (toggleWr) wr = ~wr;
      cyc++;
    end
    I_WrRdy = 1;
    chk("wr_beats", sent, nBeats);
    chk("wr_words", words, nBeats / 2);
  endtask

  initial begin : main
    logic [IW-1:0] wA, wB;
    logic [PW-1:0] expBeat [4];
    int got; int pops; int cyc; int acks; bit dr; bit popNow;

    rst = 1; I_Dat = '0; I_ISAVld = 0; I_DatVld = 0; I_DatLast = 0; I_DatRdy = 0;
    I_ISARdy = 0; I_CmdReqVld = 0; I_CmdDir = 0; I_CmdAddr = '0; I_CmdNum = '0;
    I_WrRdy = 1; I_RdDat = '0; I_RdVld = 0; I_MonReq = 0; I_MonDat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkIdleOutputs("reset");
    @(posedge clk); #1;
    rst = 0;

    // 1: 23-beat ISA stream with toggling decoder ready
    isaXfer(23, 32'hA5A5_0001);

    // 2: write command, Dir=0 Addr=0x100 Num=4, 8 host beats
    issueCmd(1'b0, 32'h0000_0100, 16'd4);
    hostWrite(8, 8, 1'b0, 32'hD0D0_0002);
    chk("errlen_clean", O_ErrLen, 0);

    // 3: read command, Dir=1 Num=2, host ready at 50% duty
    wA = {128'hA1A1_A1A1_0000_0000_0000_0000_0000_A1A1, 128'hA0A0_A0A0_0000_0000_0000_0000_0000_A0A0};
    wB = {128'hB1B1_B1B1_0000_0000_0000_0000_0000_B1B1, 128'hB0B0_B0B0_0000_0000_0000_0000_0000_B0B0};
    expBeat[0] = wA[127:0]; expBeat[1] = wA[255:128];
    expBeat[2] = wB[127:0]; expBeat[3] = wB[255:128];
    I_RdVld = 1; I_RdDat = wA;
    issueCmd(1'b1, 32'h0000_0200, 16'd2);
    got = 0; pops = 0; cyc = 0; dr = 1'b1;
    while (got < 4 && cyc < 100) begin
      I_DatRdy = dr;
      @(negedge clk);
      popNow = O_RdRdy && I_RdVld;
      if (O_DatVld && I_DatRdy) begin
        chk("rd_oe", O_DatOE, 1);
        chk("rd_dat", O_Dat, expBeat[got]);
        chk("rd_last", O_DatLast, (got == 3));
        got++;
      end
      @(posedge clk); #1;
      if (popNow) begin
        pops++;
        I_RdDat = (pops == 1) ? wB : '0;
        I_RdVld = (pops < 2);
      end
      dr = ~dr; cyc++;
    end
    I_DatRdy = 0; I_RdVld = 0;
    chk("rd_beats", got, 4);
    chk("rd_pops", pops, 2);

    // 4: I_DatLast on beat 5 of 8 sets the sticky error; transfer still runs 8 beats
    issueCmd(1'b0, 32'h0000_0300, 16'd4);
    hostWrite(8, 5, 1'b1, 32'hE0E0_0004);
    chk("errlen_set", O_ErrLen, 1);
    I_DatVld = 1; I_Dat = mkBeat(32'hE0E0_0004, 9);
    @(negedge clk);
    chk("no_ninth_beat", O_DatRdy, 0);
    @(posedge clk); #1;
    I_DatVld = 0;

    // 5: ISA and command request together -> ISA first, then the command
    I_CmdReqVld = 1; I_CmdDir = 0; I_CmdAddr = 32'h0000_0020; I_CmdNum = 16'd1;
    isaXfer(3, 32'hC0C0_0005);
    issueCmd(1'b0, 32'h0000_0020, 16'd1);
    hostWrite(2, 2, 1'b0, 32'hF0F0_0005);
    chk("errlen_sticky", O_ErrLen, 1);

    // 6: reset while beat 3 of a write is on the bus
    issueCmd(1'b0, 32'h0000_0400, 16'd4);
    got = 0; cyc = 0;
    I_DatVld = 1; I_Dat = mkBeat(32'h9999_0006, 0); I_DatLast = 0;
    while (got < 2 && cyc < 50) begin
      @(negedge clk); popNow = I_DatVld && O_DatRdy;
      @(posedge clk); #1;
      if (popNow) begin got++; I_Dat = mkBeat(32'h9999_0006, got); end
      cyc++;
    end
    chk("partial_beats", got, 2);
    rst = 1;
    @(negedge clk);
    chkIdleOutputs("mid_reset");
    @(posedge clk); #1;
    rst = 0; I_DatVld = 0;
    issueCmd(1'b0, 32'h0000_0040, 16'd1);
    hostWrite(2, 2, 1'b0, 32'h7777_0006);
    chk("errlen_after_reset", O_ErrLen, 0);

`ifdef ITF_MON_EN
    // Monitor dump: 16 beats, LSB beat first, one ack pulse
    for (int i = 0; i < 16; i++) I_MonDat[i*PW +: PW] = mkBeat(32'hB0B0_0007, i);
    I_MonReq = 1;
    @(posedge clk); #1;
    I_MonReq = 0; I_MonDat = '0;
    got = 0; cyc = 0; dr = 1'b1;
    while (got < 16 && cyc < 100) begin
      I_DatRdy = dr;
      @(negedge clk);
      if (O_DatVld && I_DatRdy) begin
        chk("mon_dat", O_Dat, mkBeat(32'hB0B0_0007, got));
        chk("mon_last", O_DatLast, (got == 15));
        chk("mon_flags", {O_DatOE, O_CmdVld}, 2'b10);
        got++;
      end
      @(posedge clk); #1;
      dr = ~dr; cyc++;
    end
    I_DatRdy = 0;
    chk("mon_beats", got, 16);
    acks = 0;
    repeat (4) begin
      @(negedge clk); acks += int'(O_MonAck);
      @(posedge clk); #1;
    end
    chk("mon_ack", acks, 1);
`else
    // Monitor path absent: request is ignored
    I_MonReq = 1; I_MonDat = '1;
    repeat (4) begin
      @(negedge clk);
      chk("mon_ignored", {O_DatOE, O_DatVld, O_MonAck}, 3'b000);
      @(posedge clk); #1;
    end
    I_MonReq = 0; I_MonDat = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
